// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Reads back a multiplexed seven-segment display. The scanned cathode bus
//   and anode enables are registered, and each digit dwell is debounced with a
//   stability counter. The digit is then decoded into a per-digit shadow slot.
//   Once all eight digits have been captured, the shadow is published as one
//   32-bit word together with its blank and error masks.
//
// Ports
//   Clk          system clock, rising edge
//   Rst          asynchronous reset, active high
//   seg_in[6:0]  cathodes, active low (bit6=a .. bit0=g)
//   en_in[7:0]   anode enables, active low, bit k selects digit k
//   value[31:0]  last complete frame, digit k in value[4k+3:4k]
//   blank_mask   bit k: digit k was all-off in the last frame
//   err_mask     bit k: digit k held an undecodable pattern in the last frame
//   frame_valid  one-cycle pulse when value/blank_mask/err_mask update
//   digits_seen  digits captured so far in the current, incomplete frame

// One shadow slot per digit. The o_* outputs show the value the slot will
// hold after this edge, so a frame can be published in the same cycle as its
// final capture.
module sevenseg_digit_slot (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_wr,
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  input  logic       i_err,
  output logic [3:0] o_nib,
  output logic       o_blank,
  output logic       o_err
);
  logic [3:0] r_nib;
  logic       r_blank;
  logic       r_err;

  // A recapture overwrites the slot, so the latest value wins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_nib   <= 4'h0;
      r_blank <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_wr) begin
      r_nib   <= i_nib;
      r_blank <= i_blank;
      r_err   <= i_err;
    end
  end

  assign o_nib   = i_wr ? i_nib   : r_nib;
  assign o_blank = i_wr ? i_blank : r_blank;
  assign o_err   = i_wr ? i_err   : r_err;
endmodule

module sevenseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [6:0]  seg_in,
  input  logic [7:0]  en_in,
  output logic [31:0] value,
  output logic [7:0]  blank_mask,
  output logic [7:0]  err_mask,
  output logic        frame_valid,
  output logic [7:0]  digits_seen
);
  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

  // Decoded cathode pattern packed as {err, blank, nibble}.
  function automatic logic [5:0] f_decode(input logic [6:0] s);
    case (s)
      7'h01:   f_decode = {2'b00, 4'h0};
      7'h4F:   f_decode = {2'b00, 4'h1};
      7'h12:   f_decode = {2'b00, 4'h2};
      7'h06:   f_decode = {2'b00, 4'h3};
      7'h4C:   f_decode = {2'b00, 4'h4};
      7'h24:   f_decode = {2'b00, 4'h5};
      7'h20:   f_decode = {2'b00, 4'h6};
      7'h0F:   f_decode = {2'b00, 4'h7};
      7'h00:   f_decode = {2'b00, 4'h8};
      7'h04:   f_decode = {2'b00, 4'h9};
      7'h08:   f_decode = {2'b00, 4'hA};
      7'h60:   f_decode = {2'b00, 4'hB};
      7'h31:   f_decode = {2'b00, 4'hC};
      7'h42:   f_decode = {2'b00, 4'hD};
      7'h30:   f_decode = {2'b00, 4'hE};
      7'h38:   f_decode = {2'b00, 4'hF};
      7'h7F:   f_decode = {2'b01, 4'h0};
      default: f_decode = {2'b10, 4'h0};
    endcase
  endfunction

  // Input stage. The *_p copies are the previous cycle's samples and are
  // used for change detection.
  logic [6:0] r_seg_q, r_seg_p;
  logic [7:0] r_en_q,  r_en_p;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_seg_q <= 7'h7F;
      r_en_q  <= 8'hFF;
      r_seg_p <= 7'h7F;
      r_en_p  <= 8'hFF;
    end else begin
      r_seg_q <= seg_in;
      r_en_q  <= en_in;
      r_seg_p <= r_seg_q;
      r_en_p  <= r_en_q;
    end
  end

  logic       w_en_valid;
  logic       w_changed;
  logic [2:0] w_idx;
  logic [7:0] w_idx_oh;
  logic [5:0] w_dec;

  // The digit index is meaningful only when exactly one anode is low.
  always_comb begin
    w_en_valid = ($countones(~r_en_q) == 1);
    w_changed  = (r_seg_q != r_seg_p) || (r_en_q != r_en_p);
    w_idx      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!r_en_q[k]) w_idx = 3'(k);
    end
    w_idx_oh = 8'h01 << w_idx;
    w_dec    = f_decode(r_seg_q);
  end

  // Dwell FSM. The counter holds the number of identical valid samples seen
  // so far. It saturates at 255 so that a long settle never wraps back below
  // the threshold.
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic       w_capture;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_WAIT;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = 8'd0;
        if (w_en_valid) begin
          w_cnt_nxt = 8'd1;
          // A one-sample threshold captures on the first valid cycle.
          if (LP_STABLE <= 8'd1) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HELD;
          end else begin
            w_state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (!w_en_valid || w_changed) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_WAIT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= LP_STABLE) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HELD;
          end
        end
      end
      S_HELD: begin
        // The digit has been captured once. Wait for the scan to move on.
        if (w_changed) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // Per-digit shadow slots.
  logic [7:0][3:0] w_shadow_nib;
  logic [7:0]      w_shadow_blank;
  logic [7:0]      w_shadow_err;

  for (genvar k = 0; k < 8; k++) begin : g_slot
    sevenseg_digit_slot u_slot (
      .Clk     (Clk),
      .Rst     (Rst),
      .i_wr    (w_capture && (w_idx == 3'(k))),
      .i_nib   (w_dec[3:0]),
      .i_blank (w_dec[4]),
      .i_err   (w_dec[5]),
      .o_nib   (w_shadow_nib[k]),
      .o_blank (w_shadow_blank[k]),
      .o_err   (w_shadow_err[k])
    );
  end

  // Frame tracking and publish.
  logic [31:0] r_value;
  logic [7:0]  r_blank_mask;
  logic [7:0]  r_err_mask;
  logic        r_frame_valid;
  logic [7:0]  r_digits_seen;
  logic [7:0]  w_seen_nxt;

  assign w_seen_nxt = r_digits_seen | w_idx_oh;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_value       <= 32'h0;
      r_blank_mask  <= 8'h00;
      r_err_mask    <= 8'h00;
      r_frame_valid <= 1'b0;
      r_digits_seen <= 8'h00;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_capture) begin
        if (w_seen_nxt == 8'hFF) begin
          r_value       <= w_shadow_nib;
          r_blank_mask  <= w_shadow_blank;
          r_err_mask    <= w_shadow_err;
          r_frame_valid <= 1'b1;
          r_digits_seen <= 8'h00;
        end else begin
          r_digits_seen <= w_seen_nxt;
        end
      end
    end
  end

  assign value       = r_value;
  assign blank_mask  = r_blank_mask;
  assign err_mask    = r_err_mask;
  assign frame_valid = r_frame_valid;
  assign digits_seen = r_digits_seen;
endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart of the top-level multiplexed seven-segment display driver: samples the scanned cathode bus and anode enables, then reconstructs the eight displayed hex digits as a 32-bit word.
- Used in loopback/self-check benches and on-board debug to read back what the processor is displaying without a camera or manual inspection.
- Debounces scan transitions with a stability counter and emits one frame pulse each time all eight digits have been captured.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of seg_in/en_in required before a digit is captured (legal range 1..255).

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  cathodes, active-low; bit6=a, bit5=b … bit0=g.
- en_in  in  8  anode enables, active-low; bit k selects digit k (digit 0 = value[3:0]).
- value  out  32  last complete frame; digit k in value[4k+3:4k].
- blank_mask  out  8  bit k set if digit k was all-off in the last frame.
- err_mask  out  8  bit k set if digit k held an undecodable pattern in the last frame.
- frame_valid  out  1  one-cycle pulse when value/blank_mask/err_mask update.
- digits_seen  out  8  digits captured so far in the current, incomplete frame.

Behaviour:
- Reset (async, Rst=1): value=0, blank_mask=0, err_mask=0, frame_valid=0, digits_seen=0, stability counter=0, FSM=WAIT. Mid-frame reset discards partial captures.
- Registered input stage: seg_in/en_in sampled into seg_q/en_q each cycle; all decisions use the registered copies.
- One-hot check: en_q is valid only when exactly one bit is 0. en_q=8'hFF (all off) or multiple zeros is invalid.
- FSM states:
  - WAIT: counter=0. If en_q is valid, go to SETTLE with counter=1.
  - SETTLE: if en_q is invalid, or seg_q/en_q differ from the previous cycle, go to WAIT. Otherwise increment the counter; when it reaches STABLE_CYCLES, capture the digit and go to HELD. With STABLE_CYCLES=1, capture happens on the first valid cycle.
  - HELD: stay until en_q or seg_q changes, then go to WAIT. A digit is captured at most once per dwell, regardless of dwell length.
- Capture of digit k:
  - Nibble decode of seg_q: 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38 (hex, 7-bit).
  - seg_q=7F: nibble 0, blank bit k set.
  - Any other pattern: nibble 0, err bit k set.
  - Result goes into a shadow word/masks; digits_seen[k] is set.
  - Recapture of an already-seen digit before the frame completes overwrites the shadow value (latest wins).
- Frame completion:
  - On the cycle digits_seen would become 8'hFF, the shadow (including the digit captured that cycle) is copied to value/blank_mask/err_mask, frame_valid=1 for exactly one cycle, and digits_seen clears to 0.
- Latency: value updates STABLE_CYCLES+2 cycles after the final digit's inputs settle at the pins.
- Counter width is 8 bits and saturates; it never wraps.

Test Plan:
- Reset mid-frame: scan digits 0-3 with STABLE_CYCLES=4, assert Rst → digits_seen=0, value=0, and no frame_valid until 8 new digits are captured.
- Clean scan: drive digits 0..7 as 1,2,3,4,5,6,7,8 with 16-cycle dwell each → single frame_valid pulse, value=32'h87654321, blank_mask=0, err_mask=0.
- Glitch filter: 2-cycle dwell on en_in=8'hFE with seg 4F, then a 16-cycle clean scan of all digits showing F → no capture from the glitch, value=32'hFFFFFFFF.
- Blank and error: digit 7 driven 7F, digit 6 driven 7E, others 0 → value=32'h00000000, blank_mask=8'h80, err_mask=8'h40.
- Invalid anode: en_in=8'hFC (two active) held for 50 cycles → no capture, digits_seen unchanged; all-off 8'hFF behaves the same.
- Repeat digit: digit 0 shown 3 then 9 (separate dwells) before digits 1..7 → value[3:0]=9, exactly one frame_valid pulse.
